// File: rtl/nios2vga_pio_pkg.sv
// Shared definitions for the Nios II -> VGA output PIO: register map,
// STATUS bit positions and the pulse generator state encoding.
package nios2vga_pio_pkg;

  // Word addresses of the slave registers
  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_PULSE    = 3'd1;
  localparam logic [2:0] ADDR_OUTSET   = 3'd2;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd3;
  localparam logic [2:0] ADDR_STATUS   = 3'd4;
  localparam logic [2:0] ADDR_IRQMASK  = 3'd5;

  // STATUS register bit positions
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;

  // Pulse generator states
  typedef enum logic {
    PULSE_IDLE   = 1'b0,
    PULSE_ACTIVE = 1'b1
  } pulse_state_e;

endpackage

// File: rtl/pio_pulse_gen.sv
// Timed strobe generator: latches a non-zero pattern onto pulse_port for
// exactly PULSE_LEN cycles, then flags done and a maskable level interrupt.
module pio_pulse_gen
  import nios2vga_pio_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PULSE_LEN  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] start_data,
  input  logic                  status_clr,
  input  logic                  irq_mask,
  output logic [DATA_WIDTH-1:0] pulse_port,
  output logic                  busy,
  output logic                  done,
  output logic                  irq
);

  localparam int CNT_W = $clog2(PULSE_LEN + 1);

  pulse_state_e          state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] pulse_q, pulse_d;
  logic                  done_q, done_d;
  logic                  done_set;
  logic                  irq_q;

  // Next-state, counter and done-flag logic
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    pulse_d  = pulse_q;
    done_set = 1'b0;
    unique case (state_q)
      PULSE_IDLE: begin
        if (start && (|start_data)) begin
          state_d = PULSE_ACTIVE;
          pulse_d = start_data;
          cnt_d   = CNT_W'(PULSE_LEN - 1);
        end
      end
      PULSE_ACTIVE: begin
        // New PULSE writes are ignored here, including on the final cycle.
        if (cnt_q == '0) begin
          state_d  = PULSE_IDLE;
          pulse_d  = '0;
          done_set = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = PULSE_IDLE;
    endcase
    // A completion in the same cycle as a software clear keeps done set.
    done_d = done_set ? 1'b1 : (status_clr ? 1'b0 : done_q);
  end

  // State registers; irq tracks the next done value so both rise together
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: reset is asynchronous, so a strobe in flight is dropped at once
    // without generating done.
    if (reset) begin
      state_q <= PULSE_IDLE;
      cnt_q   <= '0;
      pulse_q <= '0;
      done_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
      irq_q   <= done_d & irq_mask;
    end
  end

  assign pulse_port = pulse_q;
  assign busy       = (state_q == PULSE_ACTIVE);
  assign done       = done_q;
  assign irq        = irq_q;

endmodule

// File: rtl/nios2vga_pio_out.sv
// Avalon-MM output PIO driving VGA/tracking control bits: level DATA
// register with set/clear aliases, a timed strobe, and a registered read mux.
module nios2vga_pio_out
  import nios2vga_pio_pkg::*;
#(
  parameter int          DATA_WIDTH  = 8,
  parameter int unsigned RESET_VALUE = 0,
  parameter int          PULSE_LEN   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] pulse_port,
  output logic                  irq
);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  mask_q;
  logic                  busy;
  logic                  done;
  logic [31:0]           rd_mux;
  logic [31:0]           readdata_q;

  // Only the low DATA_WIDTH bits plus STATUS/IRQMASK control bits matter.
  wire unused_wd = &{1'b0, writedata};

  assign wr_en = chipselect && !write_n;
  assign wd    = writedata[DATA_WIDTH-1:0];

  pio_pulse_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .PULSE_LEN  (PULSE_LEN)
  ) u_pulse_gen (
    .clk        (clk),
    .reset      (reset),
    .start      (wr_en && (address == ADDR_PULSE)),
    .start_data (wd),
    .status_clr (wr_en && (address == ADDR_STATUS) && writedata[STATUS_DONE_BIT]),
    .irq_mask   (mask_q),
    .pulse_port (pulse_port),
    .busy       (busy),
    .done       (done),
    .irq        (irq)
  );

  // DATA and IRQMASK registers, written directly or through set/clear aliases
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= DATA_WIDTH'(RESET_VALUE);
      mask_q <= 1'b0;
    end else if (wr_en) begin
      unique case (address)
        ADDR_DATA:     data_q <= wd;
        ADDR_OUTSET:   data_q <= data_q | wd;
        ADDR_OUTCLEAR: data_q <= data_q & ~wd;
        ADDR_IRQMASK:  mask_q <= writedata[0];
        default:       ;
      endcase
    end
  end

  // Read mux for the currently presented address; unused bits read 0
  always_comb begin
    rd_mux = '0;
    unique case (address)
      ADDR_DATA:    rd_mux[DATA_WIDTH-1:0] = data_q;
      ADDR_PULSE:   rd_mux[DATA_WIDTH-1:0] = pulse_port;
      ADDR_STATUS: begin
        rd_mux[STATUS_BUSY_BIT] = busy;
        rd_mux[STATUS_DONE_BIT] = done;
      end
      ADDR_IRQMASK: rd_mux[0] = mask_q;
      default:      rd_mux = '0;
    endcase
  end

  // Registered read data, refreshed every cycle (one-cycle latency)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) readdata_q <= '0;
    else       readdata_q <= rd_mux;
  end

  assign readdata = readdata_q;
  assign out_port = data_q;

endmodule

// File: tb/tb_nios2vga_pio_out.sv
// Directed self-checking bench for nios2vga_pio_out (DATA_WIDTH=8,
// RESET_VALUE=0x3C, PULSE_LEN=16). Inputs change and outputs are sampled
// on the falling clock edge.
module tb_nios2vga_pio_out;

  localparam int DW = 8;

  logic          clk;
  logic          reset;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [DW-1:0] out_port;
  logic [DW-1:0] pulse_port;
  logic          irq;

  int checks   = 0;
  int failures = 0;

  nios2vga_pio_out #(
    .DATA_WIDTH  (DW),
    .RESET_VALUE ('h3C),
    .PULSE_LEN   (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .pulse_port (pulse_port),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One write cycle; returns on the falling edge after the write edge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  // Present an address and return readdata one cycle later.
  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    address = a;
    @(negedge clk);
    v = readdata;
  endtask

  logic [31:0] v;

  initial begin
    reset      = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_out_port", 32'(out_port), 32'h3C);
    check("rst_pulse", 32'(pulse_port), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_readdata", readdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    rd(3'd4, v); check("rst_status", v, 32'h0);
    rd(3'd5, v); check("rst_mask", v, 32'h0);

    // Level register with set/clear aliases
    wr(3'd0, 32'hA5); check("data_wr", 32'(out_port), 32'hA5);
    rd(3'd0, v);      check("data_rd", v, 32'hA5);
    wr(3'd2, 32'h0A); check("outset", 32'(out_port), 32'hAF);
    rd(3'd0, v);      check("outset_rd", v, 32'hAF);
    wr(3'd3, 32'h81); check("outclr", 32'(out_port), 32'h2E);
    rd(3'd0, v);      check("outclr_rd", v, 32'h2E);
    rd(3'd2, v);      check("outset_rd0", v, 32'h0);
    rd(3'd3, v);      check("outclr_rd0", v, 32'h0);

    // Basic strobe: high 16 cycles, STATUS busy during, done after
    wr(3'd1, 32'h03);
    address = 3'd4;
    for (int i = 1; i <= 16; i++) begin
      check($sformatf("strobe_c%0d", i), 32'(pulse_port), 32'h03);
      if (i >= 2) check($sformatf("strobe_busy_c%0d", i), readdata, 32'h1);
      @(negedge clk);
    end
    check("strobe_end", 32'(pulse_port), 32'h0);
    check("strobe_irq_masked", 32'(irq), 32'h0);
    check("strobe_data_kept", 32'(out_port), 32'h2E);
    @(negedge clk);
    check("strobe_done", readdata, 32'h2);
    wr(3'd4, 32'h2);
    rd(3'd4, v); check("done_cleared", v, 32'h0);

    // Writes while busy are ignored
    wr(3'd1, 32'h01);           // cycle 1
    repeat (3) @(negedge clk);  // cycle 4
    wr(3'd1, 32'h80);           // cycle 5
    check("busy_ign_80", 32'(pulse_port), 32'h01);
    wr(3'd1, 32'h00);           // cycle 6
    for (int i = 6; i <= 16; i++) begin
      check($sformatf("busy_ign_c%0d", i), 32'(pulse_port), 32'h01);
      @(negedge clk);
    end
    check("busy_ign_end", 32'(pulse_port), 32'h0);
    @(negedge clk);
    check("busy_ign_stays0", 32'(pulse_port), 32'h0);
    wr(3'd4, 32'h2);

    // Interrupt rises with done when unmasked
    wr(3'd5, 32'h1);
    rd(3'd5, v); check("mask_rd", v, 32'h1);
    wr(3'd1, 32'h04);
    repeat (15) @(negedge clk);
    check("irq_pre_pulse", 32'(pulse_port), 32'h04);
    check("irq_pre", 32'(irq), 32'h0);
    @(negedge clk);
    check("irq_post_pulse", 32'(pulse_port), 32'h0);
    check("irq_set", 32'(irq), 32'h1);
    rd(3'd4, v); check("irq_status", v, 32'h2);
    wr(3'd4, 32'h2);
    check("irq_cleared", 32'(irq), 32'h0);
    rd(3'd4, v); check("irq_status_clr", v, 32'h0);

    // STATUS clear in the same cycle as completion: set wins
    wr(3'd1, 32'h08);
    repeat (15) @(negedge clk);
    wr(3'd4, 32'h2);
    check("race_pulse", 32'(pulse_port), 32'h0);
    check("race_irq", 32'(irq), 32'h1);
    rd(3'd4, v); check("race_status", v, 32'h2);

    // Mask change reaches irq one cycle later
    wr(3'd5, 32'h0);
    check("mask_lag", 32'(irq), 32'h1);
    @(negedge clk);
    check("mask_off", 32'(irq), 32'h0);
    wr(3'd4, 32'h2);

    // PULSE write on the completing edge is ignored
    wr(3'd1, 32'h10);
    repeat (15) @(negedge clk);
    wr(3'd1, 32'h20);
    check("last_edge_ign", 32'(pulse_port), 32'h0);
    @(negedge clk);
    check("last_edge_ign2", 32'(pulse_port), 32'h0);
    wr(3'd4, 32'h2);

    // Unmapped addresses and zero pulse
    wr(3'd6, 32'hFF);
    check("unmapped_data", 32'(out_port), 32'h2E);
    rd(3'd6, v); check("rd_addr6", v, 32'h0);
    rd(3'd7, v); check("rd_addr7", v, 32'h0);
    wr(3'd5, 32'h1);
    wr(3'd1, 32'h00);
    check("zero_pulse", 32'(pulse_port), 32'h0);
    repeat (20) @(negedge clk);
    check("zero_irq", 32'(irq), 32'h0);
    rd(3'd4, v); check("zero_status", v, 32'h0);

    // Asynchronous reset mid-strobe
    wr(3'd1, 32'hFF);
    address = 3'd0;
    repeat (3) @(negedge clk);
    check("pre_rst_pulse", 32'(pulse_port), 32'hFF);
    check("pre_rst_rd", readdata, 32'h2E);
    #1 reset = 1'b1;
    #1;
    check("async_rst_out", 32'(out_port), 32'h3C);
    check("async_rst_pulse", 32'(pulse_port), 32'h0);
    check("async_rst_irq", 32'(irq), 32'h0);
    check("async_rst_rd", readdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    rd(3'd4, v); check("post_rst_status", v, 32'h0);
    rd(3'd5, v); check("post_rst_mask", v, 32'h0);
    check("post_rst_irq", 32'(irq), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
